// File: rtl/switch_allocator_rr_pkg.sv
// switch_allocator_rr_pkg: allocator sizes, slot type and round-robin pointer helper
package switch_allocator_rr_pkg;
  localparam int NUM_INPORTS = 5;
  localparam int NUM_OUTPORTS = 5;
  localparam int NUM_VCS = 2;
  localparam bit BYPASS_RELEASE_DEF = 1'b1;
  localparam int INPORT_W = $clog2(NUM_INPORTS) + (NUM_INPORTS == 1);
  localparam int OUTPORT_W = $clog2(NUM_OUTPORTS) + (NUM_OUTPORTS == 1);
  localparam int VC_W = $clog2(NUM_VCS) + (NUM_VCS == 1);
  typedef struct packed {
    logic [OUTPORT_W-1:0] outport;
    logic [VC_W-1:0] vc;
  } slot_t;
  function automatic logic [INPORT_W-1:0] rr_next(input logic [INPORT_W-1:0] w);
    return (int'(w) + 1 == NUM_INPORTS) ? '0 : w + INPORT_W'(1);
  endfunction
endpackage

// File: rtl/switch_allocator_rr_if.sv
// switch_allocator_rr_if: request inputs (req_valid/outport/vc, hold, vc_ready) and allocation outputs (grant, alloc_fail, select, enable)
interface switch_allocator_rr_if;
  import switch_allocator_rr_pkg::*;
  logic [NUM_INPORTS-1:0] req_valid;
  logic [NUM_INPORTS-1:0][OUTPORT_W-1:0] req_outport;
  logic [NUM_INPORTS-1:0][VC_W-1:0] req_vc;
  logic [NUM_INPORTS-1:0] hold;
  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0] vc_ready;
  logic [NUM_INPORTS-1:0] grant;
  logic [NUM_INPORTS-1:0] alloc_fail;
  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0][INPORT_W-1:0] select;
  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0] enable;
  modport master (output req_valid, req_outport, req_vc, hold, vc_ready, input grant, alloc_fail, select, enable);
  modport slave (input req_valid, req_outport, req_vc, hold, vc_ready, output grant, alloc_fail, select, enable);
endinterface

// File: rtl/switch_allocator_rr_arbiter.sv
// switch_allocator_rr_arbiter: combinational round-robin pick over req_i starting at ptr_i -> gnt_onehot_o, gnt_idx_o, any_o
module switch_allocator_rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]                 req_i,
  input  logic [$clog2(N)+(N==1)-1:0]  ptr_i,
  output logic [N-1:0]                 gnt_onehot_o,
  output logic [$clog2(N)+(N==1)-1:0]  gnt_idx_o,
  output logic                         any_o
);
  localparam int W = $clog2(N) + (N == 1);
  int idx;
  always_comb begin
    gnt_onehot_o = '0;
    gnt_idx_o = '0;
    any_o = 1'b0;
    idx = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (!any_o && req_i[idx]) begin
        any_o = 1'b1;
        gnt_idx_o = W'(idx);
        gnt_onehot_o[idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/switch_allocator_rr.sv
// switch_allocator_rr: per-slot round-robin switch allocator with credit gating and release bypass; ports clk, rst, bus (slave)
module switch_allocator_rr
  import switch_allocator_rr_pkg::*;
#(
  parameter bit BYPASS_RELEASE = BYPASS_RELEASE_DEF
) (
  input logic clk,
  input logic rst,
  switch_allocator_rr_if.slave bus
);
  typedef logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0] slot_mask_t;
  typedef logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0][INPORT_W-1:0] slot_idx_t;
  slot_mask_t enable_q, enable_d, rel, keep, slot_free, gnt_any;
  slot_idx_t select_q, select_d, ptr_q, ptr_d, gnt_idx;
  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0][NUM_INPORTS-1:0] slot_req, gnt_oh;
  logic [NUM_INPORTS-1:0] grant_q, grant_d, fail_q, fail_d, owned, elig;
  slot_t req_slot [NUM_INPORTS];
  always_comb begin
    rel = '0;
    keep = '0;
    slot_free = '0;
    owned = '0;
    elig = '0;
    slot_req = '0;
    req_slot = '{default: '0};
    for (int o = 0; o < NUM_OUTPORTS; o++)
      for (int v = 0; v < NUM_VCS; v++) begin
        rel[o][v] = enable_q[o][v] && !bus.hold[select_q[o][v]];
        keep[o][v] = enable_q[o][v] && !rel[o][v];
        slot_free[o][v] = (!enable_q[o][v] || (BYPASS_RELEASE && rel[o][v])) && bus.vc_ready[o][v];
        if (keep[o][v]) owned[select_q[o][v]] = 1'b1;
      end
    for (int i = 0; i < NUM_INPORTS; i++) begin
      req_slot[i] = '{outport: bus.req_outport[i], vc: bus.req_vc[i]};
      elig[i] = bus.req_valid[i] && int'(req_slot[i].outport) < NUM_OUTPORTS && !owned[i];
    end
    for (int o = 0; o < NUM_OUTPORTS; o++)
      for (int v = 0; v < NUM_VCS; v++)
        for (int i = 0; i < NUM_INPORTS; i++)
          slot_req[o][v][i] = elig[i] && slot_free[o][v] &&
                              int'(req_slot[i].outport) == o && int'(req_slot[i].vc) == v;
  end
  for (genvar o = 0; o < NUM_OUTPORTS; o++) begin : g_out
    for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
      switch_allocator_rr_arbiter #(.N(NUM_INPORTS)) u_arb (
        .req_i        (slot_req[o][v]),
        .ptr_i        (ptr_q[o][v]),
        .gnt_onehot_o (gnt_oh[o][v]),
        .gnt_idx_o    (gnt_idx[o][v]),
        .any_o        (gnt_any[o][v])
      );
    end
  end
  always_comb begin
    enable_d = keep;
    select_d = select_q;
    ptr_d = ptr_q;
    grant_d = '0;
    for (int o = 0; o < NUM_OUTPORTS; o++)
      for (int v = 0; v < NUM_VCS; v++)
        if (gnt_any[o][v]) begin
          enable_d[o][v] = 1'b1;
          select_d[o][v] = gnt_idx[o][v];
          ptr_d[o][v] = rr_next(gnt_idx[o][v]);
          grant_d = grant_d | gnt_oh[o][v];
        end
    fail_d = bus.req_valid & ~grant_d;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      enable_q <= '0;
      select_q <= '0;
      ptr_q <= '0;
      grant_q <= '0;
      fail_q <= '0;
    end else begin
      enable_q <= enable_d;
      select_q <= select_d;
      ptr_q <= ptr_d;
      grant_q <= grant_d;
      fail_q <= fail_d;
    end
  assign bus.grant = grant_q;
  assign bus.alloc_fail = fail_q;
  assign bus.select = select_q;
  assign bus.enable = enable_q;
endmodule

// File: tb/tb_switch_allocator_rr.sv
// tb_switch_allocator_rr: table-driven scoreboard bench for bypass and non-bypass allocators
module tb_switch_allocator_rr;
  typedef struct {
    string nm;
    logic [4:0] rv;
    logic [14:0] op;
    logic [4:0] vc;
    logic [4:0] hold;
    logic [9:0] rdy;
    logic [4:0] g;
    logic [4:0] f;
    logic [9:0] en;
  } vec_t;
  typedef struct {
    string nm;
    bit d0;
    logic [4:0] g;
    logic [4:0] f;
    logic [9:0] en;
  } exp_t;
  localparam logic [9:0] ALL = 10'h3FF;
  localparam logic [4:0] Z5 = 5'b0;
  localparam logic [9:0] Z10 = 10'h0;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  vec_t tbl[$];
  switch_allocator_rr_if if1();
  switch_allocator_rr_if if0();
  assign if0.req_valid = if1.req_valid;
  assign if0.req_outport = if1.req_outport;
  assign if0.req_vc = if1.req_vc;
  assign if0.hold = if1.hold;
  assign if0.vc_ready = if1.vc_ready;
  switch_allocator_rr #(.BYPASS_RELEASE(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  switch_allocator_rr #(.BYPASS_RELEASE(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  always #5 clk = ~clk;
  function automatic logic [14:0] ops(input int a4, input int a3, input int a2, input int a1, input int a0);
    return {3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
  endfunction
  function automatic vec_t mk(input string nm, input logic [4:0] rv, input logic [14:0] op,
                              input logic [4:0] vc, input logic [4:0] hold, input logic [9:0] rdy,
                              input logic [4:0] g, input logic [4:0] f, input logic [9:0] en);
    vec_t v;
    v.nm = nm; v.rv = rv; v.op = op; v.vc = vc; v.hold = hold; v.rdy = rdy;
    v.g = g; v.f = f; v.en = en;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic drive(input vec_t v);
    if1.req_valid = v.rv;
    if1.req_outport = v.op;
    if1.req_vc = v.vc;
    if1.hold = v.hold;
    if1.vc_ready = v.rdy;
  endtask
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.nm, e.d0 ? ".nb.grant" : ".grant"}, 10'(e.d0 ? if0.grant : if1.grant), 10'(e.g));
      chk({e.nm, e.d0 ? ".nb.fail" : ".fail"}, 10'(e.d0 ? if0.alloc_fail : if1.alloc_fail), 10'(e.f));
      chk({e.nm, e.d0 ? ".nb.enable" : ".enable"}, 10'(e.d0 ? if0.enable : if1.enable), e.en);
    end
  endtask
  task automatic apply(input vec_t v, input bit with0, input logic [4:0] g0, input logic [4:0] f0, input logic [9:0] en0);
    drive(v);
    sb.push_back('{nm: v.nm, d0: 1'b0, g: v.g, f: v.f, en: v.en});
    if (with0) sb.push_back('{nm: v.nm, d0: 1'b1, g: g0, f: f0, en: en0});
    tick();
  endtask
  initial begin
    logic [14:0] opf, opc, oph, opi, opr, opb;
    opf = ops(0, 2, 0, 2, 2);
    opc = ops(1, 0, 0, 0, 0);
    oph = ops(0, 0, 0, 0, 0);
    opi = ops(5, 3, 2, 1, 0);
    opr = ops(2, 0, 0, 0, 2);
    opb = ops(0, 0, 0, 4, 4);
    tbl.push_back(mk("fair1", 5'b01011, opf, Z5, Z5, ALL, 5'b00001, 5'b01010, 10'h010));
    tbl.push_back(mk("fair2", 5'b01010, opf, Z5, 5'b00001, ALL, Z5, 5'b01010, 10'h010));
    tbl.push_back(mk("fair3", 5'b01011, opf, Z5, Z5, ALL, 5'b00010, 5'b01001, 10'h010));
    tbl.push_back(mk("fair4", 5'b01001, opf, Z5, 5'b00010, ALL, Z5, 5'b01001, 10'h010));
    tbl.push_back(mk("fair5", 5'b01011, opf, Z5, Z5, ALL, 5'b01000, 5'b00011, 10'h010));
    tbl.push_back(mk("fair6", 5'b00011, opf, Z5, 5'b01000, ALL, Z5, 5'b00011, 10'h010));
    tbl.push_back(mk("fair7", 5'b01011, opf, Z5, Z5, ALL, 5'b00001, 5'b01010, 10'h010));
    tbl.push_back(mk("fair8", Z5, opf, Z5, Z5, ALL, Z5, Z5, Z10));
    tbl.push_back(mk("cred1", 5'b10000, opc, Z5, Z5, 10'h3FB, Z5, 5'b10000, Z10));
    tbl.push_back(mk("cred2", 5'b10000, opc, Z5, Z5, ALL, 5'b10000, Z5, 10'h004));
    tbl.push_back(mk("cred3", Z5, opc, Z5, 5'b10000, 10'h3FB, Z5, Z5, 10'h004));
    tbl.push_back(mk("cred4", Z5, opc, Z5, Z5, ALL, Z5, Z5, Z10));
    tbl.push_back(mk("hold1", 5'b00100, oph, 5'b01100, Z5, ALL, 5'b00100, Z5, 10'h002));
    for (int k = 2; k <= 6; k++)
      tbl.push_back(mk($sformatf("hold%0d", k), 5'b01000, oph, 5'b01100, 5'b00100, ALL, Z5, 5'b01000, 10'h002));
    tbl.push_back(mk("hold7", 5'b01000, oph, 5'b01100, Z5, ALL, 5'b01000, Z5, 10'h002));
    tbl.push_back(mk("hold8", Z5, oph, 5'b01100, Z5, ALL, Z5, Z5, Z10));
    tbl.push_back(mk("ind1", 5'b11111, opi, 5'b01010, Z5, ALL, 5'b01111, 5'b10000, 10'h099));
    tbl.push_back(mk("ind2", Z5, opi, 5'b01010, Z5, ALL, Z5, Z5, Z10));
    drive(mk("idle", Z5, oph, Z5, Z5, ALL, Z5, Z5, Z10));
    #1;
    chk("reset.grant", 10'(if1.grant), Z10);
    chk("reset.fail", 10'(if1.alloc_fail), Z10);
    chk("reset.enable", 10'(if1.enable), Z10);
    chk("reset.nb.enable", 10'(if0.enable), Z10);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < tbl.size(); k++) apply(tbl[k], 1'b0, Z5, Z5, Z10);
    apply(mk("rst1", 5'b01000, ops(0, 2, 0, 0, 0), 5'b01000, Z5, ALL, 5'b01000, Z5, 10'h020), 1'b0, Z5, Z5, Z10);
    chk("rst1.sel21", 10'(if1.select[2][1]), 10'd3);
    drive(mk("rsthold", Z5, oph, Z5, 5'b01000, ALL, Z5, Z5, Z10));
    #2;
    rst = 1'b1;
    #2;
    chk("rstmid.enable", 10'(if1.enable), Z10);
    chk("rstmid.grant", 10'(if1.grant), Z10);
    chk("rstmid.sel21", 10'(if1.select[2][1]), Z10);
    chk("rstmid.nb.enable", 10'(if0.enable), Z10);
    @(negedge clk);
    rst = 1'b0;
    apply(mk("rst2", 5'b10001, opr, 5'b10001, Z5, ALL, 5'b00001, 5'b10000, 10'h020), 1'b1, 5'b00001, 5'b10000, 10'h020);
    apply(mk("rst3", Z5, opr, 5'b10001, Z5, ALL, Z5, Z5, Z10), 1'b1, Z5, Z5, Z10);
    apply(mk("byp1", 5'b00010, opb, 5'b00011, Z5, ALL, 5'b00010, Z5, 10'h200), 1'b1, 5'b00010, Z5, 10'h200);
    apply(mk("byp2", Z5, opb, 5'b00011, 5'b00010, ALL, Z5, Z5, 10'h200), 1'b1, Z5, Z5, 10'h200);
    apply(mk("byp3", 5'b00001, opb, 5'b00011, Z5, ALL, 5'b00001, Z5, 10'h200), 1'b1, Z5, 5'b00001, Z10);
    chk("byp3.sel41", 10'(if1.select[4][1]), Z10);
    apply(mk("byp4", 5'b00001, opb, 5'b00011, 5'b00001, ALL, Z5, 5'b00001, 10'h200), 1'b1, 5'b00001, Z5, 10'h200);
    chk("byp4.nb.sel41", 10'(if0.select[4][1]), Z10);
    apply(mk("byp5", Z5, opb, 5'b00011, Z5, ALL, Z5, Z5, Z10), 1'b1, Z5, Z5, Z10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
